// File: rtl/etroc1_stream_arbiter_if.sv
// Channel-side and output-side handshake bundle for the ETROC1 stream arbiter.
// master = arbiter side, slave = channel array / readout FIFO side.
interface etroc1_stream_arbiter_if #(
  parameter int DW  = 32,
  parameter int NCH = 4,
  parameter int CW  = $clog2(NCH)
);
  logic [NCH-1:0]    ch_enable;
  logic [NCH-1:0]    ch_valid;
  logic [NCH*DW-1:0] ch_data;
  logic [NCH-1:0]    ch_ready;
  logic [DW-1:0]     out_data;
  logic [CW-1:0]     out_chan;
  logic              out_valid;
  logic              out_ready;

  modport master (
    input  ch_enable, ch_valid, ch_data, out_ready,
    output ch_ready, out_data, out_chan, out_valid
  );

  modport slave (
    output ch_enable, ch_valid, ch_data, out_ready,
    input  ch_ready, out_data, out_chan, out_valid
  );
endinterface

// File: rtl/etroc1_stream_arbiter.sv
// Round-robin burst arbiter merging ETROC1 channel streams into one stream.
// Optional per-channel word counters: define ETROC1_STREAM_ARB_STATS_EN.
module etroc1_stream_arbiter #(
  parameter int DW        = 32,
  parameter int NCH       = 4,
  parameter int MAX_BURST = 16
) (
  input  logic CLK,
  input  logic RSTn,
  etroc1_stream_arbiter_if.master bus,
  output logic busy
`ifdef ETROC1_STREAM_ARB_STATS_EN
  ,
  input  logic [$clog2(NCH)-1:0] stat_sel,
  input  logic                   stat_clear,
  output logic [31:0]            stat_count
`endif
);
  localparam int CW = $clog2(NCH);
  localparam int BW = $clog2(MAX_BURST) + 1;
  localparam logic [BW-1:0] LAST = BW'(MAX_BURST - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  grant, last_grant, pick, idx;
  logic [BW-1:0]  burst_cnt;
  logic [NCH-1:0] req, ready;
  logic [DW-1:0]  word, out_data;
  logic [CW-1:0]  out_chan;
  logic           out_valid;
  logic           can_load, xfer, done, found;

  assign req      = bus.ch_valid & bus.ch_enable;
  assign can_load = !out_valid | bus.out_ready;
  assign xfer     = (state == BURST) & bus.ch_valid[grant] & ready[grant];
  assign done     = (state == BURST)
                  & ((xfer & (burst_cnt == LAST))
                  | !bus.ch_valid[grant]
                  | !bus.ch_enable[grant]);

  assign bus.ch_ready  = ready;
  assign bus.out_data  = out_data;
  assign bus.out_chan  = out_chan;
  assign bus.out_valid = out_valid;

  // first requester after the previous winner, wrapping
  always_comb begin
    pick  = last_grant;
    idx   = last_grant;
    found = 1'b0;
    for (int k = 1; k <= NCH; k++) begin
      idx = CW'((int'(last_grant) + k) % NCH);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    word = '0;
    for (int i = 0; i < NCH; i++)
      if (grant == CW'(i))
        word = bus.ch_data[i*DW +: DW];
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (|req) state_nxt = BURST;
      BURST:   if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = '0;
    busy  = 1'b0;
    if (state == BURST) begin
      ready[grant] = can_load & bus.ch_enable[grant];
      busy         = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      grant      <= '0;
      last_grant <= CW'(NCH - 1);
      burst_cnt  <= '0;
      out_data   <= '0;
      out_chan   <= '0;
      out_valid  <= 1'b0;
    end else begin
      if (state == IDLE && |req) begin
        grant     <= pick;
        burst_cnt <= '0;
      end
      if (xfer) begin
        out_data  <= word;
        out_chan  <= grant;
        out_valid <= 1'b1;
        burst_cnt <= burst_cnt + 1'b1;
      end else if (bus.out_ready) begin
        out_valid <= 1'b0;
      end
      if (done) last_grant <= grant;
    end
  end

`ifdef ETROC1_STREAM_ARB_STATS_EN
  logic [31:0] stat_q [NCH];

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < NCH; i++) stat_q[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (stat_clear)
          stat_q[i] <= '0;
        else if (out_valid && bus.out_ready
                 && out_chan == CW'(i) && stat_q[i] != '1)
          stat_q[i] <= stat_q[i] + 1'b1;
      end
    end
  end

  assign stat_count = stat_q[stat_sel];
`endif
endmodule
